// File: rtl/core_mem_pkg.sv
// Shared widths, word type and default memory map for the core memory model.
package core_mem_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   typedef logic [WORD_W-1:0] word_t;

   localparam int    IRAM_WORDS_DEF = 16384;
   localparam int    DRAM_WORDS_DEF = 16384;
   localparam word_t IRAM_BASE_DEF  = 32'h0000_0000;
   localparam word_t DRAM_BASE_DEF  = 32'h0010_0000;

   function automatic word_t region_bytes(input int words);
      return word_t'(words) << 2;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Dual-port word array: one read-only port, one read/write port with byte enables.
module mem_array
   import core_mem_pkg::*;
#(
   parameter int DEPTH = 16384,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic [AW-1:0]   rd_addr,
   output word_t           rd_data,
   input  logic [AW-1:0]   rw_addr,
   input  logic            wr_en,
   input  logic [BE_W-1:0] wr_be,
   input  word_t           wr_data,
   output word_t           rw_rdata
);

   // Name kept upper-case so benches can preload <inst>.MEM.
   word_t MEM [DEPTH];

   assign rd_data  = MEM[rd_addr];
   assign rw_rdata = MEM[rw_addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) MEM[rw_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/core_mem_model.sv
// Zero-wait-state instruction/data memory for riscv_core simulation; responses one cycle after grant.
module core_mem_model
   import core_mem_pkg::*;
#(
   parameter int    IRAM_WORDS = IRAM_WORDS_DEF,
   parameter int    DRAM_WORDS = DRAM_WORDS_DEF,
   parameter word_t IRAM_BASE  = IRAM_BASE_DEF,
   parameter word_t DRAM_BASE  = DRAM_BASE_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            instr_req,
   input  word_t           instr_addr,
   output logic            instr_gnt,
   output word_t           instr_rdata,
   output logic            instr_err,
   output logic            instr_valid,
   input  logic            data_req,
   input  logic            data_wr,
   input  word_t           data_addr,
   input  word_t           data_wdata,
   input  logic [BE_W-1:0] data_byteen,
   output logic            data_gnt,
   output word_t           data_rdata,
   output logic            data_valid
);

   localparam int    IAW        = $clog2(IRAM_WORDS);
   localparam int    DAW        = $clog2(DRAM_WORDS);
   localparam word_t IRAM_BYTES = region_bytes(IRAM_WORDS);
   localparam word_t DRAM_BYTES = region_bytes(DRAM_WORDS);

   word_t i_off, d_off_i, d_off_d;
   logic  i_ok, d_hit_i, d_hit_d;
   word_t iram_rd, iram_rw, dram_rw, dram_rd_unused;
   logic  iram_we, dram_we;

   logic  instr_valid_d, instr_valid_q, instr_err_d, instr_err_q;
   word_t instr_rdata_d, instr_rdata_q;
   logic  data_valid_d, data_valid_q;
   word_t data_rdata_d, data_rdata_q;

   assign instr_gnt = instr_req & reset_n;
   assign data_gnt  = data_req & reset_n;

   // Offsets wrap below the base, so one unsigned compare covers both bounds.
   assign i_off   = instr_addr - IRAM_BASE;
   assign i_ok    = (i_off < IRAM_BYTES) && (instr_addr[1:0] == 2'b00);
   assign d_off_i = data_addr - IRAM_BASE;
   assign d_off_d = data_addr - DRAM_BASE;
   assign d_hit_i = d_off_i < IRAM_BYTES;
   assign d_hit_d = d_off_d < DRAM_BYTES;

   assign iram_we = data_gnt & data_wr & d_hit_i;
   assign dram_we = data_gnt & data_wr & d_hit_d;

   mem_array #(.DEPTH(IRAM_WORDS)) iram (
      .clk      (clk),
      .rd_addr  (i_off[IAW+1:2]),
      .rd_data  (iram_rd),
      .rw_addr  (d_off_i[IAW+1:2]),
      .wr_en    (iram_we),
      .wr_be    (data_byteen),
      .wr_data  (data_wdata),
      .rw_rdata (iram_rw)
   );

   mem_array #(.DEPTH(DRAM_WORDS)) dram (
      .clk      (clk),
      .rd_addr  ('0),
      .rd_data  (dram_rd_unused),
      .rw_addr  (d_off_d[DAW+1:2]),
      .wr_en    (dram_we),
      .wr_be    (data_byteen),
      .wr_data  (data_wdata),
      .rw_rdata (dram_rw)
   );

   always_comb begin
      instr_valid_d = instr_gnt;
      instr_err_d   = instr_gnt & ~i_ok;
      instr_rdata_d = (instr_gnt & i_ok) ? iram_rd : '0;
      data_valid_d  = data_gnt;
      data_rdata_d  = '0;
      if (data_gnt && !data_wr) begin
         if (d_hit_d)      data_rdata_d = dram_rw;
         else if (d_hit_i) data_rdata_d = iram_rw;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_valid_q <= 1'b0;
         instr_err_q   <= 1'b0;
         instr_rdata_q <= '0;
         data_valid_q  <= 1'b0;
         data_rdata_q  <= '0;
      end else begin
         instr_valid_q <= instr_valid_d;
         instr_err_q   <= instr_err_d;
         instr_rdata_q <= instr_rdata_d;
         data_valid_q  <= data_valid_d;
         data_rdata_q  <= data_rdata_d;
      end
   end

   assign instr_valid = instr_valid_q;
   assign instr_err   = instr_err_q;
   assign instr_rdata = instr_rdata_q;
   assign data_valid  = data_valid_q;
   assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_core_mem_model.sv
// Randomised bench for core_mem_model against a byte-address memory-map model.
module tb_core_mem_model;

   localparam logic [31:0] IRAM_BASE = 32'h0000_0000;
   localparam logic [31:0] DRAM_BASE = 32'h0010_0000;
   localparam logic [31:0] IRAM_END  = IRAM_BASE + 32'd4 * 32'd16384;
   localparam logic [31:0] DRAM_END  = DRAM_BASE + 32'd4 * 32'd16384;
   localparam int          POOL      = 32;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        instr_req, instr_gnt, instr_err, instr_valid;
   logic [31:0] instr_addr, instr_rdata;
   logic        data_req, data_wr, data_gnt, data_valid;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_byteen;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] model [logic [31:0]];

   core_mem_model dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_gnt   (instr_gnt),
      .instr_rdata (instr_rdata),
      .instr_err   (instr_err),
      .instr_valid (instr_valid),
      .data_req    (data_req),
      .data_wr     (data_wr),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_byteen (data_byteen),
      .data_gnt    (data_gnt),
      .data_rdata  (data_rdata),
      .data_valid  (data_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic in_iram(input logic [31:0] a);
      return (a >= IRAM_BASE) && (a < IRAM_END);
   endfunction

   function automatic logic in_dram(input logic [31:0] a);
      return (a >= DRAM_BASE) && (a < DRAM_END);
   endfunction

   function automatic logic [31:0] rd_model(input logic [31:0] k);
      return model.exists(k) ? model[k] : 32'h0;
   endfunction

   task automatic idle();
      instr_req = 1'b0; instr_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_byteen = '0;
   endtask

   // Called just after a rising edge; drives one cycle and checks the response after the next edge.
   task automatic step(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwr, input logic [31:0] daddr, input logic [31:0] wd,
                       input logic [3:0] be);
      logic [31:0] k, ex_ir, ex_dr, nw;
      logic        ex_ie;
      instr_req = ireq; instr_addr = iaddr;
      data_req = dreq; data_wr = dwr; data_addr = daddr; data_wdata = wd; data_byteen = be;
      #1;
      chk("instr_gnt", 32'(instr_gnt), 32'(ireq));
      chk("data_gnt", 32'(data_gnt), 32'(dreq));
      ex_ie = !(in_iram(iaddr) && iaddr[1:0] == 2'b00);
      ex_ir = ex_ie ? 32'h0 : rd_model(iaddr);
      k     = {daddr[31:2], 2'b00};
      ex_dr = 32'h0;
      if (dreq && !dwr && (in_iram(k) || in_dram(k))) ex_dr = rd_model(k);
      if (dreq && dwr && (in_iram(k) || in_dram(k))) begin
         nw = rd_model(k);
         for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
         model[k] = nw;
      end
      @(posedge clk); #1;
      chk("instr_valid", 32'(instr_valid), 32'(ireq));
      chk("data_valid", 32'(data_valid), 32'(dreq));
      if (ireq) begin
         chk("instr_err", 32'(instr_err), 32'(ex_ie));
         chk("instr_rdata", instr_rdata, ex_ir);
      end
      if (dreq) chk("data_rdata", data_rdata, ex_dr);
   endtask

   function automatic logic [31:0] pick_word();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) return IRAM_BASE + 32'($urandom_range(0, POOL-1)) * 4;
      if (r < 8) return DRAM_BASE + 32'($urandom_range(0, POOL-1)) * 4;
      case ($urandom_range(0, 2))
         0:       return IRAM_END;
         1:       return DRAM_END;
         default: return 32'h8000_0000;
      endcase
   endfunction

   initial begin
      logic [31:0] ia, da;
      idle();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      instr_req = 1'b1; data_req = 1'b1;
      #1;
      chk("rst_instr_gnt", 32'(instr_gnt), 32'h0);
      chk("rst_data_gnt", 32'(data_gnt), 32'h0);
      chk("rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr_err", 32'(instr_err), 32'h0);
      chk("rst_instr_rdata", instr_rdata, 32'h0);
      chk("rst_data_valid", 32'(data_valid), 32'h0);
      chk("rst_data_rdata", data_rdata, 32'h0);
      idle();
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Preload the address pool through the data port.
      for (int i = 0; i < POOL; i++) begin
         step(1'b0, '0, 1'b1, 1'b1, IRAM_BASE + 32'(i) * 4,
              (i == 0) ? 32'h0000_0093 : (i == 1) ? 32'h0010_0113 : $urandom, 4'hF);
         step(1'b0, '0, 1'b1, 1'b1, DRAM_BASE + 32'(i) * 4, $urandom, 4'hF);
      end

      step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 4'h0);
      chk("fetch0_const", instr_rdata, 32'h0000_0093);
      step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 4'h0);
      chk("fetch4_const", instr_rdata, 32'h0010_0113);
      step(1'b0, '0, 1'b1, 1'b1, 32'h0010_0000, 32'hAABB_CCDD, 4'hF);
      step(1'b0, '0, 1'b1, 1'b0, 32'h0010_0000, '0, 4'h0);
      chk("raw_const", data_rdata, 32'hAABB_CCDD);
      step(1'b0, '0, 1'b1, 1'b1, 32'h0010_0000, 32'h1122_3344, 4'b0101);
      step(1'b0, '0, 1'b1, 1'b0, 32'h0010_0000, '0, 4'h0);
      chk("partial_const", data_rdata, 32'hAA22_CC44);
      step(1'b1, 32'h2, 1'b0, 1'b0, '0, '0, 4'h0);
      step(1'b1, IRAM_END, 1'b1, 1'b0, 32'h8000_0000, '0, 4'h0);
      step(1'b1, 32'h8, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
      step(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, 4'h0);
      chk("refetch_const", instr_rdata, 32'hDEAD_BEEF);

      for (int n = 0; n < 600; n++) begin
         ia = pick_word();
         if ($urandom_range(0, 7) == 0) ia[1:0] = 2'($urandom_range(1, 3));
         da = pick_word() | 32'($urandom_range(0, 3));
         step(1'($urandom), ia, 1'($urandom), 1'($urandom), da, $urandom, 4'($urandom));
      end

      // Reset during the response cycle of a load, with a store held through reset.
      instr_req = 1'b1; instr_addr = 32'h4;
      data_req = 1'b1; data_wr = 1'b0; data_addr = DRAM_BASE + 32'h8;
      @(posedge clk); #1;
      chk("pre_rst_data_valid", 32'(data_valid), 32'h1);
      reset_n = 1'b0;
      data_wr = 1'b1; data_wdata = 32'hFFFF_FFFF; data_byteen = 4'hF;
      #1;
      chk("mid_rst_data_valid", 32'(data_valid), 32'h0);
      chk("mid_rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("mid_rst_data_rdata", data_rdata, 32'h0);
      chk("mid_rst_instr_rdata", instr_rdata, 32'h0);
      chk("mid_rst_data_gnt", 32'(data_gnt), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("hold_rst_data_valid", 32'(data_valid), 32'h0);
      idle();
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < POOL; i++) begin
         step(1'b1, IRAM_BASE + 32'(i) * 4, 1'b1, 1'b0, DRAM_BASE + 32'(i) * 4, '0, 4'h0);
      end
      idle();
      @(posedge clk); #1;
      chk("idle_data_valid", 32'(data_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
